pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the datapath stages and pipe_ctrl.
// The master side (pipeline / hazard unit / memory ports) drives the wait
// and request conditions; the slave side (pipe_ctrl) returns per-stage
// hold and bubble controls plus mult/div status.
interface pipe_ctrl_if;
    // Wait / request conditions
    logic hazard_stall;
    logic md_start_e;
    logic md_is_div_e;
    logic i_req;
    logic i_data_ok;
    logic d_req_m;
    logic d_data_ok;

    // Stage controls
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;

    // Mult/div status
    logic md_busy;
    logic md_done;

    modport master (
        output hazard_stall, md_start_e, md_is_div_e,
        output i_req, i_data_ok, d_req_m, d_data_ok,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_m, flush_w,
        input  md_busy, md_done
    );

    modport slave (
        input  hazard_stall, md_start_e, md_is_div_e,
        input  i_req, i_data_ok, d_req_m, d_data_ok,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_m, flush_w,
        output md_busy, md_done
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage MIPS core.
// Merges data-memory waits, mult/div occupancy, hazard stalls and fetch
// waits into per-stage hold/bubble controls (highest priority first), and
// owns the mult/div occupancy counter.
// Optional feature: define PIPE_CTRL_PERF_EN to add the stall_cycles and
// md_ops performance counters as extra ports.
module pipe_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,   // stall cycles for a multiply, >= 1
    parameter int unsigned DIV_CYCLES = 32   // stall cycles for a divide, >= 1
) (
    input  logic        clk,
    input  logic        resetn,
    pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] md_ops
`endif
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // Counter preload: the start cycle itself is the first stall cycle.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic dwait, iwait, mdwait;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_w;
    logic md_busy, md_done;

    // Wait conditions seen by the priority encoder and the FSM.
    assign dwait  = bus.d_req_m & ~bus.d_data_ok;
    assign iwait  = bus.i_req & ~bus.i_data_ok;
    assign mdwait = ((state_q == RUN) & bus.md_start_e) |
                    ((state_q == MD_BUSY) & (cnt_q != 6'd0));

    // State and occupancy counter register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: start the unit when E can accept it, count down, and
    // release only once the finished instruction actually leaves E.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (bus.md_start_e && !dwait) begin
                    state_d = MD_BUSY;
                    cnt_d   = bus.md_is_div_e ? DIV_LOAD : MUL_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else if (!dwait) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // Priority encoder for stage controls; reset forces bubbles everywhere.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        md_busy = (state_q == MD_BUSY);
        md_done = (state_q == MD_BUSY) && (cnt_q == 6'd0);

        if (dwait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (mdwait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (bus.hazard_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (iwait) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end

        // NOTE: the outputs are gated directly by resetn rather than by the
        // registered state, so they take their reset values the moment
        // resetn falls, not at the next edge.
        if (!resetn) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
            md_busy = 1'b0;
            md_done = 1'b0;
        end
    end

    assign bus.stall_f = stall_f;
    assign bus.stall_d = stall_d;
    assign bus.stall_e = stall_e;
    assign bus.stall_m = stall_m;
    assign bus.flush_d = flush_d;
    assign bus.flush_e = flush_e;
    assign bus.flush_m = flush_m;
    assign bus.flush_w = flush_w;
    assign bus.md_busy = md_busy;
    assign bus.md_done = md_done;

`ifdef PIPE_CTRL_PERF_EN
    // Performance counters: fetch-stall cycles and mult/div starts (wrapping).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= 32'd0;
            md_ops       <= 32'd0;
        end else begin
            if (stall_f) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state_q == RUN) && (state_d == MD_BUSY)) begin
                md_ops <= md_ops + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic. A behavioural model tracks the mult/div instruction by its age in
// cycles since acceptance and pushes the expected controls for each cycle
// into a queue; an independent monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    typedef struct {
        logic [3:0]  stall;   // {f, d, e, m}
        logic [3:0]  flush;   // {d, e, m, w}
        logic        busy;
        logic        done;
        logic [31:0] sc;
        logic [31:0] mo;
    } exp_t;

    logic clk;
    logic resetn;

    pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] md_ops;
`endif

    pipe_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .md_ops       (md_ops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model state: age of the accepted mult/div op (0 = none),
    // its configured length, and whether an md instruction sits in E.
    int   md_age  = 0;
    int   md_len  = 0;
    bit   e_md    = 0;
    bit   e_div   = 0;
    int   sc_cnt  = 0;
    int   mo_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs and record the expected controls for it.
    task automatic step(input logic rn, input logic hs, input logic st, input logic dv,
                        input logic ir, input logic iok, input logic dr, input logic dok);
        exp_t e;
        bit   dw, iw, busy, mdw, done;
        @(posedge clk);
        #1;
        resetn           = rn;
        bus.hazard_stall = hs;
        bus.md_start_e   = st;
        bus.md_is_div_e  = dv;
        bus.i_req        = ir;
        bus.i_data_ok    = iok;
        bus.d_req_m      = dr;
        bus.d_data_ok    = dok;

        dw   = dr && !dok;
        iw   = ir && !iok;
        busy = (md_age >= 1);
        mdw  = (!busy && st) || (busy && md_age < md_len);
        done = busy && (md_age >= md_len);

        e.stall = 4'b0000;
        e.flush = 4'b0000;
        e.busy  = busy;
        e.done  = done;
        if (dw)       begin e.stall = 4'b1111; e.flush = 4'b0001; end
        else if (mdw) begin e.stall = 4'b1110; e.flush = 4'b0010; end
        else if (hs)  begin e.stall = 4'b1100; e.flush = 4'b0100; end
        else if (iw)  begin e.stall = 4'b1000; e.flush = 4'b1000; end

        if (!rn) begin
            e.stall = 4'b0000;
            e.flush = 4'b1111;
            e.busy  = 1'b0;
            e.done  = 1'b0;
            md_age  = 0;
            e_md    = 0;
            sc_cnt  = 0;
            mo_cnt  = 0;
            e.sc    = 32'd0;
            e.mo    = 32'd0;
        end else begin
            e.sc = 32'(sc_cnt);
            e.mo = 32'(mo_cnt);
            if (e.stall[3]) sc_cnt++;
            if (!busy) begin
                if (st && !dw) begin
                    md_age = 1;
                    md_len = dv ? DIV_N : MUL_N;
                    mo_cnt++;
                end
            end else if (md_age >= md_len) begin
                if (!dw) begin
                    md_age = 0;
                    e_md   = 0;   // instruction leaves E
                end
            end else begin
                md_age++;
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT controls against the queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall_fdem", 32'({bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m}), 32'(e.stall));
                check("flush_demw", 32'({bus.flush_d, bus.flush_e, bus.flush_m, bus.flush_w}), 32'(e.flush));
                check("md_busy", 32'(bus.md_busy), 32'(e.busy));
                check("md_done", 32'(bus.md_done), 32'(e.done));
`ifdef PIPE_CTRL_PERF_EN
                check("stall_cycles", stall_cycles, e.sc);
                check("md_ops", md_ops, e.mo);
`endif
            end
        end
    end

    initial begin
        resetn           = 1'b0;
        bus.hazard_stall = 1'b0;
        bus.md_start_e   = 1'b0;
        bus.md_is_div_e  = 1'b0;
        bus.i_req        = 1'b0;
        bus.i_data_ok    = 1'b0;
        bus.d_req_m      = 1'b0;
        bus.d_data_ok    = 1'b0;

        // Reset state, then release with no activity.
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);

        // Load-use stall for one cycle, then quiet.
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Divide: start held while the instruction is in E (33 cycles).
        repeat (DIV_N + 1) step(1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Multiply overlapped by a data wait from T+2 to T+6.
        repeat (2) step(1, 0, 1, 0, 0, 0, 0, 0);
        repeat (5) step(1, 0, 1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Deferred start: three cycles of data wait, then the multiply runs.
        repeat (3) step(1, 0, 1, 0, 0, 0, 1, 0);
        repeat (MUL_N + 1) step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Reset asserted while a divide has cnt = 17.
        repeat (15) step(1, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);

        // Fetch wait together with a hazard, then fetch wait alone.
        step(1, 1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0);

        // Hazard and fetch wait during a multiply, including its done cycle.
        repeat (MUL_N + 1) step(1, 1, 1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic; the md instruction stays in E until it leaves.
        for (int i = 0; i < 3000; i++) begin
            logic st, dv, rn;
            rn = ($urandom_range(0, 399) != 0);
            if (!e_md) begin
                if ($urandom_range(0, 5) == 0) begin
                    e_md  = 1;
                    e_div = ($urandom_range(0, 5) == 0);
                end
            end
            st = e_md;
            dv = e_md ? e_div : 1'($urandom_range(0, 1));
            step(rn,
                 1'($urandom_range(0, 3) == 0),
                 st, dv,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
